// File: rtl/lcd_rd.sv
// lcd_rd: read-side bus engine for an HD44780-style LCD.
// Runs one RW=1 cycle (SETUP -> STROBE -> HOLD) per request and returns the
// captured byte on a ready/valid response channel.
// Optional feature macro: LCD_RD_BUSY_POLL_EN. When it is defined, busy-flag
// reads repeat until bit7 clears or POLL_MAX reads have been made.
//
// state  | meaning
// IDLE   | bus released, waiting for a request
// SETUP  | RS/RW driven, EN low (address setup)
// STROBE | EN high, data captured on the last cycle
// HOLD   | EN low, RS/RW held (hold time)
// RESP   | response valid, waiting for consumer
module lcd_rd #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 50,
  parameter int HOLD_CYC  = 2,
  parameter int POLL_MAX  = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  output logic       req_ready_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_rs_o,
  output logic       rsp_timeout_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       bus_req_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic       en_o,
  input  logic [7:0] lcd_data_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       last_cyc;

  assign last_cyc = (cnt_q == 8'd1);

`ifdef LCD_RD_BUSY_POLL_EN
  logic [7:0] poll_q, poll_d;
  logic       timeout_q, timeout_d;
  logic [8:0] reads_done;

  // Number of reads completed once the current HOLD finishes.
  assign reads_done = {1'b0, poll_q} + 9'd1;

  // Poll counter and timeout flag; both cleared when a request is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      poll_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout_o = timeout_q;
`else
  logic unused_poll_max;
  assign unused_poll_max = (POLL_MAX > 0);
  assign rsp_timeout_o   = 1'b0;
`endif

  // State, phase timer, latched RS and captured byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; the timer is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
`ifdef LCD_RD_BUSY_POLL_EN
    poll_d    = poll_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rs_d    = req_rs_i;
          state_d = SETUP;
          cnt_d   = 8'(SETUP_CYC);
`ifdef LCD_RD_BUSY_POLL_EN
          poll_d    = 8'd0;
          timeout_d = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (last_cyc) begin
          state_d = STROBE;
          cnt_d   = 8'(EN_CYC);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (last_cyc) begin
          data_d  = lcd_data_i;
          state_d = HOLD;
          cnt_d   = 8'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (last_cyc) begin
          state_d = RESP;
`ifdef LCD_RD_BUSY_POLL_EN
          poll_d = reads_done[7:0];
          if (!rs_q && data_q[7]) begin
            if (reads_done < 9'(POLL_MAX)) begin
              state_d = SETUP;
              cnt_d   = 8'(SETUP_CYC);
            end else begin
              timeout_d = 1'b1;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign en_o        = (state_q == STROBE);
  assign bus_req_o   = (state_q != IDLE);
  assign rw_o        = bus_req_o;
  assign rs_o        = rs_q & bus_req_o;
  assign rsp_data_o  = data_q;
  assign rsp_rs_o    = rs_q;

endmodule

// File: tb/tb_lcd_rd.sv
// Directed bench for lcd_rd at default timing (4/50/2).
module tb_lcd_rd;

`ifdef LCD_RD_BUSY_POLL_EN
  localparam int TB_POLL_MAX = 4;
`else
  localparam int TB_POLL_MAX = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_ready;
  logic [7:0] rsp_data;
  logic       rsp_rs;
  logic       rsp_timeout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       bus_req;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] lcd_data = 8'h00;

  int checks = 0;
  int errors = 0;

  // Bytes returned by the LCD model: busy_reads reads of 8'h80, then final_byte.
  int         busy_reads = 0;
  logic [7:0] final_byte = 8'h00;

  lcd_rd #(
    .SETUP_CYC(4),
    .EN_CYC   (50),
    .HOLD_CYC (2),
    .POLL_MAX (TB_POLL_MAX)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_rs_i     (req_rs),
    .req_ready_o  (req_ready),
    .rsp_data_o   (rsp_data),
    .rsp_rs_o     (rsp_rs),
    .rsp_timeout_o(rsp_timeout),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .bus_req_o    (bus_req),
    .rs_o         (rs),
    .rw_o         (rw),
    .en_o         (en),
    .lcd_data_i   (lcd_data)
  );

  always #5 clk = ~clk;

  // Accept at edge T; returns at the negedge inside cycle T+1.
  task automatic start_req(input logic rs_val);
    @(negedge clk);
    req_valid = 1'b1;
    req_rs    = rs_val;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called in cycle T+1; returns k where rsp_valid first seen in cycle T+k.
  task automatic wait_resp(input int limit, output int cyc, output int pulses,
                           output int en_cycles, output int first_en);
    logic prev_en;
    cyc = 1; pulses = 0; en_cycles = 0; first_en = 0; prev_en = 1'b0;
    while (!rsp_valid && cyc < limit) begin
      if (en) begin
        en_cycles++;
        if (!prev_en) begin
          pulses++;
          if (first_en == 0) first_en = cyc;
          lcd_data = (pulses <= busy_reads) ? 8'h80 : final_byte;
        end
      end
      prev_en = en;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL resp_timeout_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, cyc);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, rsp_valid, bus_req, rs, rw, en, rsp_timeout} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 1000000",
               {req_ready, rsp_valid, bus_req, rs, rw, en, rsp_timeout});
    end
    checks++;
    if (rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h, required 00", rsp_data);
    end
  endtask

  task automatic test_data_read();
    int cyc, pulses, en_cycles, first_en;
    busy_reads = 0; final_byte = 8'h41;
    start_req(1'b1);
    checks++;
    if ({rs, rw, bus_req, req_ready, en} !== 5'b11100) begin
      errors++;
      $display("FAIL rd_setup_pins: got %b, required 11100", {rs, rw, bus_req, req_ready, en});
    end
    wait_resp(300, cyc, pulses, en_cycles, first_en);
    checks++;
    if (cyc !== 57) begin errors++; $display("FAIL rd_latency: got %0d, required 57", cyc); end
    checks++;
    if (first_en !== 5) begin errors++; $display("FAIL rd_en_start: got %0d, required 5", first_en); end
    checks++;
    if (en_cycles !== 50) begin errors++; $display("FAIL rd_en_width: got %0d, required 50", en_cycles); end
    checks++;
    if ({rsp_data, rsp_rs, rsp_timeout} !== {8'h41, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp: got data=%h rs=%b to=%b, required 41 1 0", rsp_data, rsp_rs, rsp_timeout);
    end
    handshake();
    checks++;
    if ({req_ready, rsp_valid, bus_req, rw, rs} !== 5'b10000) begin
      errors++;
      $display("FAIL rd_release: got %b, required 10000", {req_ready, rsp_valid, bus_req, rw, rs});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, pulses, en_cycles, first_en;
    busy_reads = 0; final_byte = 8'h12;
    start_req(1'b0);
    checks++;
    if ({rs, rw} !== 2'b01) begin errors++; $display("FAIL b2b_pins: got %b, required 01", {rs, rw}); end
    wait_resp(300, cyc, pulses, en_cycles, first_en);
    checks++;
    if ({cyc, pulses} !== {32'd57, 32'd1}) begin
      errors++;
      $display("FAIL b2b_timing: got cyc=%0d pulses=%0d, required 57 1", cyc, pulses);
    end
    checks++;
    if ({rsp_data, rsp_rs} !== {8'h12, 1'b0}) begin
      errors++;
      $display("FAIL b2b_rsp: got %h/%b, required 12/0", rsp_data, rsp_rs);
    end
    handshake();
  endtask

`ifndef LCD_RD_BUSY_POLL_EN
  task automatic test_busy_single();
    int cyc, pulses, en_cycles, first_en;
    busy_reads = 9; final_byte = 8'h00;
    start_req(1'b0);
    wait_resp(300, cyc, pulses, en_cycles, first_en);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d, required 1", pulses); end
    checks++;
    if ({rsp_data, rsp_timeout} !== {8'h80, 1'b0}) begin
      errors++;
      $display("FAIL busy_rsp: got %h to=%b, required 80 0", rsp_data, rsp_timeout);
    end
    handshake();
  endtask
`else
  task automatic test_poll();
    int cyc, pulses, en_cycles, first_en;
    busy_reads = 3; final_byte = 8'h05;
    start_req(1'b0);
    wait_resp(600, cyc, pulses, en_cycles, first_en);
    checks++;
    if ({cyc, pulses} !== {32'd225, 32'd4}) begin
      errors++;
      $display("FAIL poll_clear_timing: got cyc=%0d pulses=%0d, required 225 4", cyc, pulses);
    end
    checks++;
    if ({rsp_data, rsp_timeout} !== {8'h05, 1'b0}) begin
      errors++;
      $display("FAIL poll_clear_rsp: got %h to=%b, required 05 0", rsp_data, rsp_timeout);
    end
    handshake();
    busy_reads = 255; final_byte = 8'h80;
    start_req(1'b0);
    wait_resp(600, cyc, pulses, en_cycles, first_en);
    checks++;
    if (pulses !== 4) begin errors++; $display("FAIL poll_stuck_pulses: got %0d, required 4", pulses); end
    checks++;
    if ({rsp_data, rsp_timeout} !== {8'h80, 1'b1}) begin
      errors++;
      $display("FAIL poll_stuck_rsp: got %h to=%b, required 80 1", rsp_data, rsp_timeout);
    end
    handshake();
    busy_reads = 255; final_byte = 8'h80;
    start_req(1'b1);
    wait_resp(600, cyc, pulses, en_cycles, first_en);
    checks++;
    if ({pulses, 31'd0, rsp_timeout} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL poll_rs1: got pulses=%0d to=%b, required 1 0", pulses, rsp_timeout);
    end
    handshake();
  endtask
`endif

  task automatic test_backpressure();
    int cyc, pulses, en_cycles, first_en;
    int bad;
    busy_reads = 0; final_byte = 8'h3C;
    start_req(1'b1);
    wait_resp(300, cyc, pulses, en_cycles, first_en);
    bad = 0;
    req_valid = 1'b1;
    req_rs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({rsp_valid, req_ready, rsp_data, rsp_rs, bus_req} !== {1'b1, 1'b0, 8'h3C, 1'b1, 1'b1}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles, required 0", bad);
    end
    req_valid = 1'b0;
    handshake();
    checks++;
    if ({req_ready, rsp_valid, bus_req} !== 3'b100) begin
      errors++;
      $display("FAIL bp_release: got %b, required 100", {req_ready, rsp_valid, bus_req});
    end
  endtask

  task automatic test_reset_mid();
    logic saw_bad;
    busy_reads = 0; final_byte = 8'h77;
    start_req(1'b1);
    repeat (9) @(negedge clk);
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL rst_pre_en: got %b, required 1", en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en, rw, bus_req, rsp_valid, rs} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_async: got %b, required 00000", {en, rw, bus_req, rsp_valid, rs});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, bus_req} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release: got %b, required 10", {req_ready, bus_req});
    end
    rsp_ready = 1'b1;
    saw_bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || en || bus_req) saw_bad = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (saw_bad !== 1'b0) begin errors++; $display("FAIL rst_stale: got activity=%b, required 0", saw_bad); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_data_read();
    test_back_to_back();
`ifdef LCD_RD_BUSY_POLL_EN
    test_poll();
`else
    test_busy_single();
`endif
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
